// File: rtl/note_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : note_seq_pkg
// Description : Shared definitions for the note sequencer: sequencing state
//               encoding and queued-entry width helper.
// Contents    : c_ST_*       - state encoding (IDLE / PLAY / GAP)
//               entry_width  - packed {tom, nota, dur} entry width
// Revision    : 1.0 - initial release
// ============================================================================
package note_seq_pkg;

    localparam int c_STATE_W = 2;

    localparam logic [c_STATE_W-1:0] c_ST_IDLE = 2'd0;
    localparam logic [c_STATE_W-1:0] c_ST_PLAY = 2'd1;
    localparam logic [c_STATE_W-1:0] c_ST_GAP  = 2'd2;

    // Tone bit plus 3-bit note code precede the duration field in an entry.
    localparam int c_NOTE_FIELD_W = 4;

    function automatic int entry_width(input int dur_w);
        return c_NOTE_FIELD_W + dur_w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/note_fifo.sv
`default_nettype none
// ============================================================================
// Module      : note_fifo
// Description : First-word-fall-through FIFO holding queued note entries.
//               The head entry is always visible on pop_data; pop advances.
// Ports       : clk, rst_n      - clock, synchronous active-low reset
//               push, push_data - write request and entry (ignored when full)
//               pop             - advance head (ignored when empty)
//               pop_data        - current head entry
//               full, empty     - occupancy flags from registered state
// Revision    : 1.0 - initial release
// ============================================================================
module note_fifo #(
    parameter int DEPTH = 8,   // power of two, >= 2
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int c_AW = $clog2(DEPTH);
    localparam int c_CW = c_AW + 1;

    localparam logic [c_AW-1:0] c_PTR_ONE  = c_AW'(1);
    localparam logic [c_CW-1:0] c_CNT_ONE  = c_CW'(1);
    localparam logic [c_CW-1:0] c_FULL_CNT = c_CW'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_AW-1:0]  r_wr_ptr;
    logic [c_AW-1:0]  r_rd_ptr;
    logic [c_CW-1:0]  r_count;

    logic w_push;
    logic w_pop;

    assign full     = (r_count == c_FULL_CNT);
    assign empty    = (r_count == '0);
    assign w_push   = push && !full;
    assign w_pop    = pop && !empty;
    assign pop_data = r_mem[r_rd_ptr];

    // Storage needs no reset: nothing is read until the count says it is valid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_ONE;
                2'b01:   r_count <= r_count - c_CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/note_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : note_sequencer
// Description : Queues {tom, nota, dur} note entries and plays them to a
//               display driver: each note is shown for dur ticks (0 -> 1),
//               followed by a one-tick blank gap. A tick is PRESCALE clocks.
// Ports       : clk, rst_n            - clock, synchronous active-low reset
//               in_valid/in_ready     - entry handshake
//               in_tom/in_nota/in_dur - entry fields
//               start, stop           - playback request / abort
//               TOM_out, NOTAS_out    - registered note to display driver
//               blank                 - registered display-off indication
//               busy                  - high outside IDLE
//               done                  - one-cycle pulse when queue plays out
// Revision    : 1.0 - initial release
// ============================================================================
module note_sequencer
    import note_seq_pkg::*;
#(
    parameter int DEPTH    = 8,
    parameter int DUR_W    = 4,
    parameter int PRESCALE = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_tom,
    input  logic [2:0]       in_nota,
    input  logic [DUR_W-1:0] in_dur,
    input  logic             start,
    input  logic             stop,
    output logic             TOM_out,
    output logic [2:0]       NOTAS_out,
    output logic             blank,
    output logic             busy,
    output logic             done
);

    localparam int c_ENTRY_W = entry_width(DUR_W);
    localparam int c_PS_W    = $clog2(PRESCALE);

    localparam logic [c_PS_W-1:0] c_PS_LAST = c_PS_W'(PRESCALE - 1);
    localparam logic [c_PS_W-1:0] c_PS_ONE  = c_PS_W'(1);
    localparam logic [DUR_W-1:0]  c_DUR_ONE = DUR_W'(1);

    logic [c_STATE_W-1:0] r_state;
    logic [c_STATE_W-1:0] w_state_nxt;
    logic [c_PS_W-1:0]    r_cnt;
    logic [DUR_W-1:0]     r_ticks_left;
    logic                 r_tom;
    logic [2:0]           r_nota;
    logic                 r_blank;
    logic                 r_done;

    logic                 w_full;
    logic                 w_empty;
    logic [c_ENTRY_W-1:0] w_head;
    logic                 w_head_tom;
    logic [2:0]           w_head_nota;
    logic [DUR_W-1:0]     w_head_dur;
    logic                 w_tick;
    logic                 w_load;
    logic                 w_done_nxt;

    assign in_ready  = !w_full;
    assign busy      = (r_state != c_ST_IDLE);
    assign TOM_out   = r_tom;
    assign NOTAS_out = r_nota;
    assign blank     = r_blank;
    assign done      = r_done;

    assign w_head_tom  = w_head[c_ENTRY_W-1];
    assign w_head_nota = w_head[c_ENTRY_W-2 -: 3];
    assign w_head_dur  = w_head[DUR_W-1:0];
    assign w_tick      = busy && (r_cnt == c_PS_LAST);

    note_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (c_ENTRY_W)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (in_valid && in_ready),
        .push_data ({in_tom, in_nota, in_dur}),
        .pop       (w_load),
        .pop_data  (w_head),
        .full      (w_full),
        .empty     (w_empty)
    );

    // Next-state logic; stop outranks both start and tick in every state.
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_done_nxt  = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                if (!stop && start && !w_empty) begin
                    w_load      = 1'b1;
                    w_state_nxt = c_ST_PLAY;
                end
            end
            c_ST_PLAY: begin
                if (stop) begin
                    w_state_nxt = c_ST_IDLE;
                end else if (w_tick && (r_ticks_left == c_DUR_ONE)) begin
                    w_state_nxt = c_ST_GAP;
                end
            end
            c_ST_GAP: begin
                if (stop) begin
                    w_state_nxt = c_ST_IDLE;
                end else if (w_tick) begin
                    if (!w_empty) begin
                        w_load      = 1'b1;
                        w_state_nxt = c_ST_PLAY;
                    end else begin
                        w_state_nxt = c_ST_IDLE;
                        w_done_nxt  = 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Registered outputs, note-length counter and prescaler.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_tom        <= 1'b0;
            r_nota       <= 3'd0;
            r_blank      <= 1'b1;
            r_done       <= 1'b0;
            r_ticks_left <= '0;
            r_cnt        <= '0;
        end else begin
            r_done  <= w_done_nxt;
            r_blank <= (w_state_nxt != c_ST_PLAY);

            if (w_load) begin
                r_tom        <= w_head_tom;
                r_nota       <= w_head_nota;
                // A zero-length entry still shows for one tick.
                r_ticks_left <= (w_head_dur == '0) ? c_DUR_ONE : w_head_dur;
            end else if ((r_state == c_ST_PLAY) && w_tick) begin
                r_ticks_left <= r_ticks_left - c_DUR_ONE;
            end

            // Prescaler restarts on every note load and rests at 0 when idle.
            if (w_load || (w_state_nxt == c_ST_IDLE) || w_tick) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + c_PS_ONE;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_note_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_note_sequencer
// Description : Self-checking bench for note_sequencer. Accepted entries are
//               queued as expected notes (value and on-time in cycles); a
//               monitor measures each displayed note and inter-note gap from
//               the outputs and compares against that queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_note_sequencer;

    localparam int DEPTH    = 8;
    localparam int DUR_W    = 4;
    localparam int PRESCALE = 4;
    localparam int IDLE_BOUND = 3000;

    logic             clk      = 1'b0;
    logic             rst_n    = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_tom   = 1'b0;
    logic [2:0]       in_nota  = 3'd0;
    logic [DUR_W-1:0] in_dur   = '0;
    logic             start    = 1'b0;
    logic             stop     = 1'b0;
    logic             in_ready;
    logic             TOM_out;
    logic [2:0]       NOTAS_out;
    logic             blank;
    logic             busy;
    logic             done;

    note_sequencer #(
        .DEPTH    (DEPTH),
        .DUR_W    (DUR_W),
        .PRESCALE (PRESCALE)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_tom    (in_tom),
        .in_nota   (in_nota),
        .in_dur    (in_dur),
        .start     (start),
        .stop      (stop),
        .TOM_out   (TOM_out),
        .NOTAS_out (NOTAS_out),
        .blank     (blank),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    // cycles == 0 marks a note cut short by stop/reset: length not checked.
    typedef struct {
        logic       tom;
        logic [2:0] nota;
        int         cycles;
    } note_t;

    note_t sb_q[$];
    int    checks       = 0;
    int    failures     = 0;
    int    model_occ    = 0;
    int    runs_started = 0;
    int    done_seen    = 0;

    bit         in_run    = 1'b0;
    bit         run_ok    = 1'b1;
    bit         gap_valid = 1'b0;
    int         run_len   = 0;
    int         gap_len   = 0;
    logic       run_tom   = 1'b0;
    logic [2:0] run_nota  = 3'd0;

    task automatic end_run();
        note_t e;
        checks++;
        if (sb_q.size() == 0) begin
            failures++;
            $display("FAIL note_unexpected: got tom=%0d nota=%0d len=%0d, required no note",
                     run_tom, run_nota, run_len);
        end else begin
            e = sb_q.pop_front();
            if (!run_ok || run_tom !== e.tom || run_nota !== e.nota ||
                (e.cycles != 0 && run_len != e.cycles)) begin
                failures++;
                $display("FAIL note_play: got tom=%0d nota=%0d len=%0d stable=%0d, required tom=%0d nota=%0d len=%0d",
                         run_tom, run_nota, run_len, run_ok, e.tom, e.nota, e.cycles);
            end
        end
    endtask

    // Monitor: samples on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (blank === 1'b0) begin
            if (!in_run) begin
                in_run   = 1'b1;
                run_ok   = 1'b1;
                run_len  = 1;
                run_tom  = TOM_out;
                run_nota = NOTAS_out;
                runs_started++;
                model_occ--;
                checks++;
                if (busy !== 1'b1) begin
                    failures++;
                    $display("FAIL busy_in_play: got %0d, required 1", busy);
                end
                if (gap_valid) begin
                    checks++;
                    if (gap_len != PRESCALE) begin
                        failures++;
                        $display("FAIL gap_len: got %0d cycles, required %0d", gap_len, PRESCALE);
                    end
                end
                gap_valid = 1'b0;
            end else begin
                run_len++;
                if (TOM_out !== run_tom || NOTAS_out !== run_nota) run_ok = 1'b0;
            end
        end else begin
            if (in_run) begin
                in_run = 1'b0;
                end_run();
                gap_valid = busy;
                gap_len   = busy ? 1 : 0;
            end else if (gap_valid) begin
                if (busy) begin
                    gap_len++;
                end else begin
                    if (done) begin
                        checks++;
                        if (gap_len != PRESCALE) begin
                            failures++;
                            $display("FAIL gap_before_done: got %0d cycles, required %0d",
                                     gap_len, PRESCALE);
                        end
                    end
                    gap_valid = 1'b0;
                end
            end
        end
        if (done === 1'b1) begin
            done_seen++;
            checks++;
            if (sb_q.size() != 0) begin
                failures++;
                $display("FAIL done_drained: got %0d notes still pending, required 0", sb_q.size());
            end
        end
    end

    task automatic check(input string name, input int got, input int req);
        checks++;
        if (got != req) begin
            failures++;
            $display("FAIL %s: got %0d, required %0d", name, got, req);
        end
    endtask

    task automatic check_reset_vals(input string name);
        checks++;
        if (TOM_out !== 1'b0 || NOTAS_out !== 3'd0 || blank !== 1'b1 ||
            busy !== 1'b0 || done !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL %s: got tom=%0d nota=%0d blank=%0d busy=%0d done=%0d ready=%0d, required 0 0 1 0 0 1",
                     name, TOM_out, NOTAS_out, blank, busy, done, in_ready);
        end
    endtask

    // Called just after a rising edge; holds the entry for one edge.
    task automatic push_entry(input logic t, input logic [2:0] n,
                              input logic [DUR_W-1:0] d, input bit chk_ready);
        bit    accept;
        note_t e;
        in_valid = 1'b1;
        in_tom   = t;
        in_nota  = n;
        in_dur   = d;
        accept   = 1'b1;
        if (chk_ready) begin
            accept = (model_occ < DEPTH);
            check("in_ready", int'(in_ready), int'(accept));
        end
        if (accept) begin
            e.tom    = t;
            e.nota   = n;
            e.cycles = ((d == '0) ? 1 : int'(d)) * PRESCALE;
            sb_q.push_back(e);
            model_occ++;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic pulse_start(input bit expect_play, input string name);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        checks++;
        if (expect_play ? (busy !== 1'b1 || blank !== 1'b0) : (busy !== 1'b0 || blank !== 1'b1)) begin
            failures++;
            $display("FAIL %s: got busy=%0d blank=%0d, required busy=%0d blank=%0d",
                     name, busy, blank, expect_play, !expect_play);
        end
    endtask

    task automatic wait_idle(input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < IDLE_BOUND; i++) begin
            @(posedge clk); #1;
            if (!busy && !in_run) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL %s: got still busy after %0d cycles, required idle", name, IDLE_BOUND);
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic wait_runs(input int target, input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < IDLE_BOUND; i++) begin
            @(posedge clk); #1;
            if (runs_started >= target) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL %s: got %0d notes started, required %0d", name, runs_started, target);
        end
    endtask

    task automatic watch_quiet(input int cycles, input string name);
        bit bad;
        bad = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (busy !== 1'b0 || blank !== 1'b1 || done !== 1'b0) bad = 1'b1;
        end
        @(posedge clk); #1;
        check(name, int'(bad), 0);
    endtask

    initial begin
        int d0;
        int r0;
        int n;
        int extra;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check_reset_vals("reset_vals");
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Start with nothing queued is ignored
        d0 = done_seen;
        pulse_start(1'b0, "start_empty");
        watch_quiet(16, "empty_quiet");
        check("empty_no_done", done_seen, d0);

        // Single note, dur 2: 8 cycles shown, 4 blank, then done
        d0 = done_seen;
        r0 = runs_started;
        push_entry(1'b0, 3'b101, 4'd2, 1'b1);
        pulse_start(1'b1, "start_latency");
        check("first_nota", int'(NOTAS_out), 5);
        wait_idle("idle_single");
        check("single_done", done_seen, d0 + 1);
        check("single_runs", runs_started, r0 + 1);
        check("single_busy", int'(busy), 0);

        // Zero duration shows for one tick
        d0 = done_seen;
        push_entry(1'b1, 3'b010, 4'd0, 1'b1);
        pulse_start(1'b1, "start_dur0");
        wait_idle("idle_dur0");
        check("dur0_done", done_seen, d0 + 1);

        // Fill to DEPTH with in_valid held; ninth offer refused
        for (int k = 0; k < DEPTH + 1; k++) begin
            push_entry(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                       DUR_W'($urandom_range(0, 3)), 1'b1);
        end
        check("full_not_ready", int'(in_ready), 0);
        d0 = done_seen;
        r0 = runs_started;
        pulse_start(1'b1, "start_full");
        wait_idle("idle_full");
        check("full_runs", runs_started, r0 + DEPTH);
        check("full_done", done_seen, d0 + 1);
        check("full_drained", sb_q.size(), 0);

        // Stop during the second of three notes, then resume with the third
        r0 = runs_started;
        d0 = done_seen;
        push_entry(1'b0, 3'd1, 4'd2, 1'b1);
        push_entry(1'b1, 3'd2, 4'd2, 1'b1);
        push_entry(1'b0, 3'd3, 4'd2, 1'b1);
        pulse_start(1'b1, "start_stop_case");
        wait_runs(r0 + 2, "second_note");
        if (sb_q.size() > 0) sb_q[0].cycles = 0;
        stop = 1'b1;
        @(posedge clk); #1;
        stop = 1'b0;
        checks++;
        if (busy !== 1'b0 || blank !== 1'b1) begin
            failures++;
            $display("FAIL stop_idle: got busy=%0d blank=%0d, required busy=0 blank=1", busy, blank);
        end
        watch_quiet(12, "stop_quiet");
        check("stop_no_done", done_seen, d0);
        pulse_start(1'b1, "start_after_stop");
        check("resume_nota", int'(NOTAS_out), 3);
        wait_idle("idle_resume");
        check("resume_runs", runs_started, r0 + 3);
        check("resume_done", done_seen, d0 + 1);

        // Reset mid-playback with three entries still queued
        r0 = runs_started;
        for (int k = 0; k < 4; k++) push_entry(1'b1, 3'(k + 4), 4'd3, 1'b1);
        pulse_start(1'b1, "start_reset_case");
        repeat (3) @(posedge clk);
        #1;
        if (sb_q.size() > 0) sb_q[0].cycles = 0;
        rst_n = 1'b0;
        @(posedge clk); #1;
        check_reset_vals("reset_mid_play");
        @(posedge clk); #1;
        rst_n = 1'b1;
        sb_q.delete();
        model_occ = 0;
        d0 = done_seen;
        pulse_start(1'b0, "start_after_reset");
        watch_quiet(16, "reset_quiet");
        check("reset_no_done", done_seen, d0);

        // Randomised sessions, some with entries added during playback
        for (int r = 0; r < 10; r++) begin
            n = $urandom_range(1, 6);
            for (int k = 0; k < n; k++) begin
                push_entry(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                           DUR_W'($urandom_range(0, 4)), 1'b1);
            end
            d0 = done_seen;
            r0 = runs_started;
            extra = $urandom_range(0, 2);
            pulse_start(1'b1, "start_rand");
            for (int k = 0; k < extra; k++) begin
                push_entry(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                           DUR_W'($urandom_range(0, 4)), 1'b0);
            end
            wait_idle("idle_rand");
            check("rand_runs", runs_started, r0 + n + extra);
            check("rand_done", done_seen, d0 + 1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got simulation still running, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/note_sequencer.md
NOTE_SEQUENCER -- requirements
Module: note_sequencer

Interface
REQ-001 Parameter DEPTH, default 8, SHALL set queued note entries (power of two).
REQ-002 Parameter DUR_W, default 4, SHALL set duration field width in ticks.
REQ-003 Parameter PRESCALE, default 4, SHALL set clock cycles per tick (>=2).
REQ-004 Clock  input  1  SHALL be the single clock; all state changes occur on its rising edge.
REQ-005 Reset  input  1  SHALL be synchronous, active-low reset.
REQ-006 in_valid  input  1  SHALL qualify an offered note entry.
REQ-007 in_ready  output  1  SHALL indicate an entry can be accepted.
REQ-008 in_tom  input  1  SHALL carry the entry tone bit.
REQ-009 in_nota  input  3  SHALL carry the entry note code.
REQ-010 in_dur  input  DUR_W  SHALL carry the entry hold length in ticks.
REQ-011 start  input  1  SHALL request playback of the queue.
REQ-012 stop  input  1  SHALL abort playback.
REQ-013 TOM_out  output  1  SHALL drive the display driver tone input.
REQ-014 NOTAS_out  output  3  SHALL drive the display driver note inputs.
REQ-015 blank  output  1  SHALL indicate display output must be ignored/off.
REQ-016 busy  output  1  SHALL be high in every state except IDLE.
REQ-017 done  output  1  SHALL pulse one cycle when the queue plays out completely.

Function
REQ-018 Queue SHALL be a FIFO of DEPTH entries {tom, nota, dur}; push when in_valid && in_ready.
REQ-019 in_ready SHALL equal !full, registered-state derived, independent of in_valid.
REQ-020 Push and pop in the same cycle SHALL both occur when not full; occupancy unchanged.
REQ-021 Pointers SHALL wrap modulo DEPTH; occupancy counter SHALL range 0..DEPTH.
REQ-022 States SHALL be IDLE, PLAY, GAP.
REQ-023 IDLE: start with queue non-empty SHALL pop head into current-note registers and enter PLAY next cycle; start with queue empty SHALL be ignored.
REQ-024 Prescaler SHALL count 0..PRESCALE-1 only while busy, cleared on entering PLAY; tick asserts in the cycle count = PRESCALE-1.
REQ-025 PLAY: TOM_out/NOTAS_out SHALL show current note, blank=0, held for dur ticks; dur=0 SHALL be treated as 1.
REQ-026 PLAY SHALL go to GAP on the final tick of the note.
REQ-027 GAP SHALL hold blank=1 for exactly one tick; on that tick, queue non-empty -> pop next entry, enter PLAY; empty -> enter IDLE with done=1 for one cycle.
REQ-028 Entries pushed during playback SHALL be played if present when GAP ends.
REQ-029 stop SHALL take priority over start and tick: next cycle state=IDLE, blank=1, no done pulse, queue contents retained.
REQ-030 start while busy SHALL be ignored.
REQ-031 Outputs TOM_out, NOTAS_out, blank, done SHALL be registered.

Reset
REQ-032 Reset low at a rising edge SHALL force: state IDLE, queue empty, pointers 0, prescaler 0, TOM_out=0, NOTAS_out=0, blank=1, busy=0, done=0, in_ready=1 from the following cycle.
REQ-033 Reset mid-playback SHALL discard current note and all queued entries.

Structure
REQ-034 Shared package note_seq_pkg SHALL hold state encoding and entry-width constant (4+DUR_W).
REQ-035 The FIFO SHALL be a sub-module note_fifo (push/pop/full/empty/data); sequencing FSM and prescaler stay in note_sequencer.

Verification
REQ-036 Push {0,3'b101,dur=2}, start -> NOTAS_out=101, blank=0 for 8 cycles (PRESCALE=4), then blank=1 for 4 cycles, done pulse, busy=0.
REQ-037 Push 8 entries with in_valid held -> in_ready=0 after 8th push; 9th entry not accepted; playback emits all 8 in order.
REQ-038 Entry dur=0 -> displayed for exactly 1 tick (4 cycles).
REQ-039 Start with empty queue -> busy stays 0, blank stays 1, no done.
REQ-040 Stop during second of three notes -> IDLE next cycle, blank=1, no done; later start plays third note only.
REQ-041 Reset asserted mid-PLAY with 3 queued -> all outputs at reset values; subsequent start ignored (queue empty).
